// File: rtl/latency_meter_pkg.sv
// Shared constants, readback map and packet-state type for the latency meter.
package latency_meter_pkg;

    localparam int LAT_W  = 32;
    localparam int BEAT_W = 16;

    localparam logic [2:0] RB_COUNT      = 3'd0;
    localparam logic [2:0] RB_MIN        = 3'd1;
    localparam logic [2:0] RB_MAX        = 3'd2;
    localparam logic [2:0] RB_SUM        = 3'd3;
    localparam logic [2:0] RB_LAST_LAT   = 3'd4;
    localparam logic [2:0] RB_LAST_BEATS = 3'd5;
    localparam logic [2:0] RB_SUM_OVF    = 3'd6;
    localparam logic [2:0] RB_BADCODE    = 3'd7;

    localparam logic [LAT_W-1:0] MIN_INIT = 32'hFFFF_FFFF;
    localparam logic [63:0]      BADCODE  = 64'h0BAD_C0DE_0BAD_C0DE;

    typedef enum logic {
        ST_SOP  = 1'b0,
        ST_BODY = 1'b1
    } pkt_state_e;

    function automatic logic [BEAT_W-1:0] beat_inc(input logic [BEAT_W-1:0] v);
        return (v == '1) ? v : v + BEAT_W'(1);
    endfunction

endpackage

// File: rtl/axi_skid_buffer.sv
// Two-entry registered skid stage: output register plus one overflow slot.
// Upstream ready depends only on the registered overflow flag.
module axi_skid_buffer #(
    parameter int W = 161
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_s_data,
    input  logic         i_s_valid,
    output logic         o_s_ready,
    output logic [W-1:0] o_m_data,
    output logic         o_m_valid,
    input  logic         i_m_ready
);

    logic [W-1:0] r_out_data;
    logic [W-1:0] r_skid_data;
    logic         r_out_valid;
    logic         r_skid_valid;
    logic         w_in_fire;
    logic         w_out_free;

    assign o_s_ready  = !r_skid_valid && !i_rst;
    assign w_in_fire  = i_s_valid && o_s_ready;
    assign w_out_free = !r_out_valid || i_m_ready;
    assign o_m_data   = r_out_data;
    assign o_m_valid  = r_out_valid;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_skid_data  <= '0;
            r_skid_valid <= 1'b0;
        end else if (w_out_free) begin
            // A full skid slot blocks new input, so it always drains first.
            if (r_skid_valid) begin
                r_out_data   <= r_skid_data;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_out_valid <= w_in_fire;
                if (w_in_fire) begin
                    r_out_data <= i_s_data;
                end
            end
        end else if (w_in_fire) begin
            r_skid_data  <= i_s_data;
            r_skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/latency_meter.sv
// Stream pass-through that measures per-packet latency (timer minus tuser timestamp)
// on each packet's first beat and keeps count/min/max/sum/last statistics.
module latency_meter
    import latency_meter_pkg::*;
#(
    parameter int SUM_W = 48,
    parameter int CNT_W = 32
) (
    input  logic         ce_clk,
    input  logic         ce_rst,
    input  logic         clear,
    input  logic [63:0]  timer,
    input  logic [31:0]  i_tdata,
    input  logic [127:0] i_tuser,
    input  logic         i_tlast,
    input  logic         i_tvalid,
    output logic         i_tready,
    output logic [31:0]  o_tdata,
    output logic [127:0] o_tuser,
    output logic         o_tlast,
    output logic         o_tvalid,
    input  logic         o_tready,
    input  logic [2:0]   rb_sel,
    output logic [63:0]  rb_data,
    output logic         stat_stb
);

    localparam int SKID_W = 1 + 128 + 32;

    logic [SKID_W-1:0] w_s_data;
    logic [SKID_W-1:0] w_m_data;
    logic              w_s_ready;
    logic              w_accept;
    logic              w_sample;
    logic              w_sop;
    logic              w_unused_timer_hi;

    pkt_state_e        r_state;
    pkt_state_e        w_state_next;
    logic [BEAT_W-1:0] r_beat_cnt;

    logic [CNT_W-1:0]  r_count;
    logic [LAT_W-1:0]  r_min;
    logic [LAT_W-1:0]  r_max;
    logic [SUM_W-1:0]  r_sum;
    logic [LAT_W-1:0]  r_last_lat;
    logic [BEAT_W-1:0] r_last_beats;
    logic              r_sum_ovf;
    logic              r_stat_stb;
    logic [63:0]       r_rb_data;

    logic [CNT_W-1:0]  w_base_count;
    logic [LAT_W-1:0]  w_base_min;
    logic [LAT_W-1:0]  w_base_max;
    logic [SUM_W-1:0]  w_base_sum;
    logic [BEAT_W-1:0] w_base_last_beats;
    logic              w_base_ovf;
    logic [LAT_W-1:0]  w_lat;
    logic [SUM_W:0]    w_sum_ext;

    assign w_s_data = {i_tlast, i_tuser, i_tdata};
    assign {o_tlast, o_tuser, o_tdata} = w_m_data;
    assign i_tready = w_s_ready;
    assign w_accept = i_tvalid && w_s_ready;
    assign w_sample = w_accept && w_sop;
    assign rb_data  = r_rb_data;
    assign stat_stb = r_stat_stb;
    assign w_unused_timer_hi = ^timer[63:32];

    axi_skid_buffer #(
        .W(SKID_W)
    ) u_skid (
        .i_clk     (ce_clk),
        .i_rst     (ce_rst),
        .i_s_data  (w_s_data),
        .i_s_valid (i_tvalid),
        .o_s_ready (w_s_ready),
        .o_m_data  (w_m_data),
        .o_m_valid (o_tvalid),
        .i_m_ready (o_tready)
    );

    always_ff @(posedge ce_clk or posedge ce_rst) begin
        if (ce_rst) begin
            r_state <= ST_SOP;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_SOP:  if (w_accept && !i_tlast) w_state_next = ST_BODY;
            ST_BODY: if (w_accept && i_tlast)  w_state_next = ST_SOP;
            default: w_state_next = ST_SOP;
        endcase
    end

    always_comb begin
        w_sop = (r_state == ST_SOP);
    end

    always_ff @(posedge ce_clk or posedge ce_rst) begin
        if (ce_rst) begin
            r_beat_cnt <= '0;
        end else if (w_accept) begin
            r_beat_cnt <= i_tlast ? '0 : beat_inc(r_beat_cnt);
        end
    end

    // Clear is folded in ahead of the sample so a coincident sample starts fresh.
    always_comb begin
        w_base_count      = clear ? '0       : r_count;
        w_base_min        = clear ? MIN_INIT : r_min;
        w_base_max        = clear ? '0       : r_max;
        w_base_sum        = clear ? '0       : r_sum;
        w_base_last_beats = clear ? '0       : r_last_beats;
        w_base_ovf        = clear ? 1'b0     : r_sum_ovf;
        w_lat             = timer[LAT_W-1:0] - i_tuser[LAT_W-1:0];
        w_sum_ext         = {1'b0, w_base_sum} + {{(SUM_W + 1 - LAT_W){1'b0}}, w_lat};
    end

    always_ff @(posedge ce_clk or posedge ce_rst) begin
        if (ce_rst) begin
            r_count      <= '0;
            r_min        <= MIN_INIT;
            r_max        <= '0;
            r_sum        <= '0;
            r_last_lat   <= '0;
            r_last_beats <= '0;
            r_sum_ovf    <= 1'b0;
            r_stat_stb   <= 1'b0;
        end else begin
            r_stat_stb   <= w_sample;
            r_last_beats <= (w_accept && i_tlast) ? beat_inc(r_beat_cnt) : w_base_last_beats;
            if (w_sample) begin
                r_count    <= (w_base_count == '1) ? w_base_count : w_base_count + CNT_W'(1);
                r_min      <= (w_lat < w_base_min) ? w_lat : w_base_min;
                r_max      <= (w_lat > w_base_max) ? w_lat : w_base_max;
                r_last_lat <= w_lat;
                if (w_sum_ext[SUM_W]) begin
                    r_sum     <= '1;
                    r_sum_ovf <= 1'b1;
                end else begin
                    r_sum     <= w_sum_ext[SUM_W-1:0];
                    r_sum_ovf <= w_base_ovf;
                end
            end else begin
                r_count    <= w_base_count;
                r_min      <= w_base_min;
                r_max      <= w_base_max;
                r_sum      <= w_base_sum;
                r_sum_ovf  <= w_base_ovf;
                r_last_lat <= clear ? '0 : r_last_lat;
            end
        end
    end

    always_ff @(posedge ce_clk or posedge ce_rst) begin
        if (ce_rst) begin
            r_rb_data <= '0;
        end else begin
            case (rb_sel)
                RB_COUNT:      r_rb_data <= 64'(r_count);
                RB_MIN:        r_rb_data <= 64'(r_min);
                RB_MAX:        r_rb_data <= 64'(r_max);
                RB_SUM:        r_rb_data <= 64'(r_sum);
                RB_LAST_LAT:   r_rb_data <= 64'(r_last_lat);
                RB_LAST_BEATS: r_rb_data <= 64'(r_last_beats);
                RB_SUM_OVF:    r_rb_data <= {63'd0, r_sum_ovf};
                RB_BADCODE:    r_rb_data <= BADCODE;
                default:       r_rb_data <= BADCODE;
            endcase
        end
    end

endmodule
